// File: rtl/pc_predict.sv
// -----------------------------------------------------------------------------
// pc_predict
// Fetch-address generator for the IF stage. It holds the program counter and
// uses a direct-mapped branch target buffer (BTB) with 2-bit saturating
// counters to predict taken branches at fetch. Branches resolved in EX are
// compared with the prediction they carried from IF. A wrong prediction
// raises a redirect and flush request, and it increments a saturating
// performance counter.
//
// Parameters
//   WIDTH        address width (>= 8)
//   BTB_ENTRIES  number of BTB entries (power of two, >= 2)
//   RESET_PC     fetch address after reset
//   CNT_W        width of the mispredict counter
//
// Ports
//   clk_i              clock
//   rst_i              synchronous active-high reset
//   pcen               advance PC (0 = stall)
//   pcaddr             current fetch address (registered)
//   next_pc            value pcaddr takes at the next edge if it updates
//   pred_taken         BTB predicts that pcaddr is a taken branch
//   pred_target        predicted target (0 when pred_taken = 0)
//   id_jump_valid      jump resolved in ID
//   id_jump_target     jump target from ID
//   ex_br_valid        branch resolved in EX this cycle
//   ex_br_pc           address of that branch
//   ex_br_taken        actual outcome
//   ex_br_target       actual taken target
//   ex_br_pred         prediction carried with the branch from IF
//   ex_br_pred_target  predicted target carried from IF
//   mispredict         redirect; the pipeline flushes IF/ID and ID/EX
//   mispred_count      saturating count of mispredicts (registered)
// -----------------------------------------------------------------------------
module pc_predict #(
  parameter int               WIDTH       = 32,
  parameter int               BTB_ENTRIES = 16,
  parameter logic [WIDTH-1:0] RESET_PC    = '0,
  parameter int               CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pcen,
  output logic [WIDTH-1:0] pcaddr,
  output logic [WIDTH-1:0] next_pc,
  output logic             pred_taken,
  output logic [WIDTH-1:0] pred_target,
  input  logic             id_jump_valid,
  input  logic [WIDTH-1:0] id_jump_target,
  input  logic             ex_br_valid,
  input  logic [WIDTH-1:0] ex_br_pc,
  input  logic             ex_br_taken,
  input  logic [WIDTH-1:0] ex_br_target,
  input  logic             ex_br_pred,
  input  logic [WIDTH-1:0] ex_br_pred_target,
  output logic             mispredict,
  output logic [CNT_W-1:0] mispred_count
);

  localparam int               IDX     = $clog2(BTB_ENTRIES);
  localparam int               TAG_W   = WIDTH - IDX - 2;
  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(32'd4);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(32'd1);
  localparam logic [1:0]       CTR_ALLOC = 2'b10;

  // Saturating increment of a 2-bit prediction counter.
  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    logic [1:0] r;
    if (c == 2'b11) begin
      r = 2'b11;
    end else begin
      r = c + 2'b01;
    end
    return r;
  endfunction

  // Saturating decrement of a 2-bit prediction counter.
  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    logic [1:0] r;
    if (c == 2'b00) begin
      r = 2'b00;
    end else begin
      r = c - 2'b01;
    end
    return r;
  endfunction

  // BTB storage.
  logic             btb_valid_q  [BTB_ENTRIES];
  logic [TAG_W-1:0] btb_tag_q    [BTB_ENTRIES];
  logic [WIDTH-1:0] btb_target_q [BTB_ENTRIES];
  logic [1:0]       btb_ctr_q    [BTB_ENTRIES];

  logic [WIDTH-1:0] pc_q;
  logic [CNT_W-1:0] mispred_count_q;
  logic [CNT_W-1:0] mispred_count_d;

  // Lookup uses the fetch address. Update uses the resolving branch address.
  logic [IDX-1:0]   lk_idx_s;
  logic [TAG_W-1:0] lk_tag_s;
  logic             lk_hit_s;
  logic [IDX-1:0]   up_idx_s;
  logic [TAG_W-1:0] up_tag_s;
  logic             up_hit_s;
  logic             pc_load_s;

  assign lk_idx_s = pcaddr[IDX+1:2];
  assign lk_tag_s = pcaddr[WIDTH-1:IDX+2];
  assign up_idx_s = ex_br_pc[IDX+1:2];
  assign up_tag_s = ex_br_pc[WIDTH-1:IDX+2];

  assign pcaddr        = pc_q;
  assign mispred_count = mispred_count_q;

  // BTB lookup for the current fetch address. It reads the pre-edge contents.
  always_comb begin
    lk_hit_s    = 1'b0;
    pred_taken  = 1'b0;
    pred_target = '0;
    if (btb_valid_q[lk_idx_s] && (btb_tag_q[lk_idx_s] == lk_tag_s)) begin
      lk_hit_s = 1'b1;
    end else begin
      lk_hit_s = 1'b0;
    end
    if (lk_hit_s && btb_ctr_q[lk_idx_s][1]) begin
      pred_taken  = 1'b1;
      pred_target = btb_target_q[lk_idx_s];
    end else begin
      pred_taken  = 1'b0;
      pred_target = '0;
    end
  end

  // Hit detection for the EX-stage update.
  always_comb begin
    up_hit_s = 1'b0;
    if (btb_valid_q[up_idx_s] && (btb_tag_q[up_idx_s] == up_tag_s)) begin
      up_hit_s = 1'b1;
    end else begin
      up_hit_s = 1'b0;
    end
  end

  // Mispredict detection. A wrong direction is a mispredict. A correctly
  // predicted taken branch with the wrong target is also a mispredict.
  always_comb begin
    mispredict = 1'b0;
    if (ex_br_valid) begin
      if (ex_br_taken != ex_br_pred) begin
        mispredict = 1'b1;
      end else if (ex_br_taken && ex_br_pred && (ex_br_target != ex_br_pred_target)) begin
        mispredict = 1'b1;
      end else begin
        mispredict = 1'b0;
      end
    end else begin
      mispredict = 1'b0;
    end
  end

  // Next fetch address. The EX redirect outranks the ID jump, because the
  // jump is then on the wrong path and is flushed.
  always_comb begin
    next_pc = pcaddr + PC_STEP;
    if (mispredict) begin
      if (ex_br_taken) begin
        next_pc = ex_br_target;
      end else begin
        next_pc = ex_br_pc + PC_STEP;
      end
    end else if (id_jump_valid) begin
      next_pc = id_jump_target;
    end else if (pred_taken) begin
      next_pc = pred_target;
    end else begin
      next_pc = pcaddr + PC_STEP;
    end
  end

  // A redirect loads the PC even during a stall, so it is never lost.
  assign pc_load_s = pcen | mispredict;

  // Program counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q <= RESET_PC;
    end else if (pc_load_s) begin
      pc_q <= next_pc;
    end else begin
      pc_q <= pc_q;
    end
  end

  // Saturating mispredict counter next-state.
  always_comb begin
    mispred_count_d = mispred_count_q;
    if (mispredict && (mispred_count_q != CNT_MAX)) begin
      mispred_count_d = mispred_count_q + CNT_ONE;
    end else begin
      mispred_count_d = mispred_count_q;
    end
  end

  // Mispredict counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mispred_count_q <= '0;
    end else begin
      mispred_count_q <= mispred_count_d;
    end
  end

  // BTB training. It is independent of pcen. Reset wins over an update in
  // the same cycle. A not-taken miss leaves the table alone, so cold
  // fall-through branches do not evict useful entries.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid_q[i]  <= 1'b0;
        btb_tag_q[i]    <= '0;
        btb_target_q[i] <= '0;
        btb_ctr_q[i]    <= 2'b00;
      end
    end else if (ex_br_valid) begin
      if (up_hit_s) begin
        if (ex_br_taken) begin
          btb_ctr_q[up_idx_s]    <= ctr_inc(btb_ctr_q[up_idx_s]);
          btb_target_q[up_idx_s] <= ex_br_target;
        end else begin
          btb_ctr_q[up_idx_s]    <= ctr_dec(btb_ctr_q[up_idx_s]);
        end
      end else if (ex_br_taken) begin
        btb_valid_q[up_idx_s]  <= 1'b1;
        btb_tag_q[up_idx_s]    <= up_tag_s;
        btb_target_q[up_idx_s] <= ex_br_target;
        btb_ctr_q[up_idx_s]    <= CTR_ALLOC;
      end else begin
        btb_valid_q[up_idx_s]  <= btb_valid_q[up_idx_s];
      end
    end else begin
      btb_valid_q[up_idx_s] <= btb_valid_q[up_idx_s];
    end
  end

endmodule

// File: tb/tb_pc_predict.sv
// Directed bench for pc_predict. The DUT has a 2-entry BTB, 16-bit addresses
// and a 3-bit mispredict counter. With 2 entries the index is pc[2] and the
// tag is pc[15:3].
module tb_pc_predict;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         pcen;
  logic [W-1:0] pcaddr, next_pc, pred_target;
  logic         pred_taken, mispredict;
  logic         id_jump_valid;
  logic [W-1:0] id_jump_target;
  logic         ex_br_valid, ex_br_taken, ex_br_pred;
  logic [W-1:0] ex_br_pc, ex_br_target, ex_br_pred_target;
  logic [2:0]   mispred_count;

  int n_checks = 0;
  int n_pass   = 0;

  pc_predict #(
    .WIDTH      (16),
    .BTB_ENTRIES(2),
    .RESET_PC   (16'h0400),
    .CNT_W      (3)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .pcen             (pcen),
    .pcaddr           (pcaddr),
    .next_pc          (next_pc),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .id_jump_valid    (id_jump_valid),
    .id_jump_target   (id_jump_target),
    .ex_br_valid      (ex_br_valid),
    .ex_br_pc         (ex_br_pc),
    .ex_br_taken      (ex_br_taken),
    .ex_br_target     (ex_br_target),
    .ex_br_pred       (ex_br_pred),
    .ex_br_pred_target(ex_br_pred_target),
    .mispredict       (mispredict),
    .mispred_count    (mispred_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Advance one clock edge and then sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_clear();
    ex_br_valid = 1'b0; ex_br_taken = 1'b0; ex_br_pred = 1'b0;
    ex_br_pc = '0; ex_br_target = '0; ex_br_pred_target = '0;
  endtask

  // Drive a resolved branch for the current cycle.
  task automatic ex_set(input logic [W-1:0] pc, input logic tk, input logic [W-1:0] tgt,
                        input logic pr, input logic [W-1:0] prt);
    ex_br_valid = 1'b1; ex_br_pc = pc; ex_br_taken = tk; ex_br_target = tgt;
    ex_br_pred = pr; ex_br_pred_target = prt;
  endtask

  // ID jump with pcen, then stall so that pcaddr stays put.
  task automatic jump(input logic [W-1:0] tgt);
    id_jump_valid = 1'b1; id_jump_target = tgt; pcen = 1'b1;
    tick();
    id_jump_valid = 1'b0; pcen = 1'b0;
    #1;
  endtask

  // Resolve a branch at 0x100 without a mispredict while the PC is stalled.
  task automatic train(input logic tk, input logic [W-1:0] tgt);
    ex_set(16'h0100, tk, tgt, tk, tgt);
    tick();
    ex_clear();
    #1;
  endtask

  initial begin
    rst = 1'b1; pcen = 1'b0; id_jump_valid = 1'b0; id_jump_target = '0;
    ex_clear();
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_pcaddr", 32'(pcaddr), 32'h400);
    check("rst_pred_taken", 32'(pred_taken), 32'h0);
    check("rst_pred_target", 32'(pred_target), 32'h0);
    check("rst_next_pc", 32'(next_pc), 32'h404);
    check("rst_count", 32'(mispred_count), 32'h0);
    check("rst_mispredict", 32'(mispredict), 32'h0);

    // Sequential fetch.
    pcen = 1'b1;
    tick(); check("seq1", 32'(pcaddr), 32'h404);
    tick(); check("seq2", 32'(pcaddr), 32'h408);
    tick(); check("seq3", 32'(pcaddr), 32'h40C);
    check("seq_pred", 32'(pred_taken), 32'h0);

    // Stall, then an ID jump.
    pcen = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("stall_hold", 32'(pcaddr), 32'h40C);
    id_jump_valid = 1'b1; id_jump_target = 16'h0800; pcen = 1'b1;
    #1;
    check("jump_next_pc", 32'(next_pc), 32'h800);
    tick();
    id_jump_valid = 1'b0; pcen = 1'b0;
    #1;
    check("jump_pcaddr", 32'(pcaddr), 32'h800);

    // Taken branch at 0x100 that was predicted not taken.
    ex_set(16'h0100, 1'b1, 16'h0200, 1'b0, 16'h0000);
    #1;
    check("br_mispredict", 32'(mispredict), 32'h1);
    check("br_next_pc", 32'(next_pc), 32'h200);
    tick(); ex_clear(); #1;
    check("br_redirect", 32'(pcaddr), 32'h200);
    check("br_count1", 32'(mispred_count), 32'h1);
    check("miss_pred_target", 32'(pred_target), 32'h0);
    jump(16'h0100);
    check("refetch_pred", 32'(pred_taken), 32'h1);
    check("refetch_target", 32'(pred_target), 32'h200);
    check("refetch_next_pc", 32'(next_pc), 32'h200);

    // Training from ctr=2. The first not-taken write also checks that a
    // lookup in the same cycle sees the old prediction.
    ex_set(16'h0100, 1'b0, 16'h0000, 1'b0, 16'h0000);
    #1;
    check("same_cycle_old", 32'(pred_taken), 32'h1);
    check("no_mispredict", 32'(mispredict), 32'h0);
    tick(); ex_clear(); #1;
    check("nt1_pred", 32'(pred_taken), 32'h0);
    check("nt1_hold", 32'(pcaddr), 32'h100);
    train(1'b0, 16'h0000);                    // ctr 0
    train(1'b1, 16'h0200);                    // ctr 1
    check("t1_pred", 32'(pred_taken), 32'h0);
    train(1'b1, 16'h0200);                    // ctr 2
    check("t2_pred", 32'(pred_taken), 32'h1);
    train(1'b1, 16'h0200);                    // ctr 3
    train(1'b1, 16'h0200);                    // ctr stays at 3
    check("t4_pred", 32'(pred_taken), 32'h1);
    train(1'b0, 16'h0000);                    // ctr 2 only if it saturated
    check("sat_nt_pred", 32'(pred_taken), 32'h1);
    train(1'b0, 16'h0000);                    // ctr 1
    check("sat_nt2_pred", 32'(pred_taken), 32'h0);

    // Correct direction with the wrong target: mispredict and retarget.
    ex_set(16'h0100, 1'b1, 16'h0300, 1'b1, 16'h0200);
    #1;
    check("tgt_mispredict", 32'(mispredict), 32'h1);
    check("tgt_next_pc", 32'(next_pc), 32'h300);
    tick(); ex_clear(); #1;
    check("tgt_pcaddr", 32'(pcaddr), 32'h300);
    check("tgt_count", 32'(mispred_count), 32'h2);
    jump(16'h0100);
    check("retarget_pred", 32'(pred_taken), 32'h1);
    check("retarget_target", 32'(pred_target), 32'h300);

    // Mispredict, ID jump and stall together: the mispredict wins.
    ex_set(16'h0500, 1'b0, 16'h0000, 1'b1, 16'h0700);
    id_jump_valid = 1'b1; id_jump_target = 16'h0900; pcen = 1'b0;
    #1;
    check("prio_next_pc", 32'(next_pc), 32'h504);
    tick(); ex_clear(); id_jump_valid = 1'b0; #1;
    check("prio_pcaddr", 32'(pcaddr), 32'h504);
    check("prio_count", 32'(mispred_count), 32'h3);

    // Tag alias: 0x108 shares index 0 with 0x100 and evicts it.
    ex_set(16'h0108, 1'b1, 16'h0180, 1'b1, 16'h0180);
    tick(); ex_clear(); #1;
    check("alias_pcaddr", 32'(pcaddr), 32'h504);
    jump(16'h0100);
    check("alias_evicted", 32'(pred_taken), 32'h0);
    jump(16'h0108);
    check("alias_pred", 32'(pred_taken), 32'h1);
    check("alias_target", 32'(pred_target), 32'h180);

    // The counter saturates at 7.
    for (int i = 0; i < 5; i++) begin
      ex_set(16'h0600, 1'b0, 16'h0000, 1'b1, 16'h0000);
      tick();
    end
    ex_clear(); #1;
    check("count_sat", 32'(mispred_count), 32'h7);

    // Address wrap-around.
    jump(16'hFFF8);
    check("wrap_next1", 32'(next_pc), 32'hFFFC);
    pcen = 1'b1;
    tick(); check("wrap_fffc", 32'(pcaddr), 32'hFFFC);
    check("wrap_next2", 32'(next_pc), 32'h0);
    tick(); check("wrap_zero", 32'(pcaddr), 32'h0);
    pcen = 1'b0;
    ex_set(16'hFFFC, 1'b0, 16'h0000, 1'b1, 16'h0000);
    #1;
    check("wrap_ex_pc4", 32'(next_pc), 32'h0);
    ex_clear();

    // Reset overrides an in-flight BTB update and counter step.
    jump(16'h0200);
    rst = 1'b1;
    ex_set(16'h0104, 1'b1, 16'h0440, 1'b0, 16'h0000);
    tick(); rst = 1'b0; ex_clear(); #1;
    check("rst2_pcaddr", 32'(pcaddr), 32'h400);
    check("rst2_count", 32'(mispred_count), 32'h0);
    jump(16'h0108);
    check("rst2_btb_clear", 32'(pred_taken), 32'h0);
    jump(16'h0104);
    check("rst2_no_alloc", 32'(pred_taken), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
